// File: rtl/mc_control_fsm.sv
// ---------------------------------------------------------------------------
// mc_control_fsm
//
// Main controller for a multicycle MIPS datapath. Each instruction is walked
// through fetch, decode, execute, memory and writeback states. The controller
// drives the datapath enables and mux selects, and produces the 2-bit aluop
// used by the ALU decoder (00 = add, 01 = subtract, 10 = use funct field).
//
// Supported opcodes: lw, sw, R-type, beq, addi, and j when MC_JUMP_EN is
// defined. Without MC_JUMP_EN, op 000010 is illegal: it pulses illegal_op
// and returns to FETCH.
//
// Parameters
//   USE_MEM_READY : 1 = FETCH/MEMRD/MEMWR wait for mem_ready,
//                   0 = mem_ready ignored (each memory state lasts one cycle)
//
// Ports
//   clk         in   rising-edge clock
//   reset_n     in   asynchronous active-low reset
//   op[5:0]     in   instr[31:26] from the instruction register
//   mem_ready   in   memory access completes this cycle
//   aluop[1:0]  out  to ALU decoder
//   alusrca     out  0 = PC, 1 = register A
//   alusrcb     out  00 = B, 01 = 4, 10 = signimm, 11 = signimm<<2
//   pcsrc[1:0]  out  00 = ALU result, 01 = ALUOut, 10 = jump target
//   iord        out  memory address select, 1 = ALUOut
//   irwrite     out  instruction register enable
//   pcwrite     out  unconditional PC enable
//   branch      out  PC enable qualified by zero in the datapath
//   regwrite    out  register file write
//   regdst      out  1 = rd, 0 = rt
//   memtoreg    out  1 = data register
//   memwrite    out  memory write strobe
//   retire      out  one-cycle pulse, instruction complete
//   illegal_op  out  one-cycle pulse, unsupported opcode in DECODE
// ---------------------------------------------------------------------------
module mc_control_fsm #(
    parameter int USE_MEM_READY = 1
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [5:0] op,
    input  logic       mem_ready,
    output logic [1:0] aluop,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] pcsrc,
    output logic       iord,
    output logic       irwrite,
    output logic       pcwrite,
    output logic       branch,
    output logic       regwrite,
    output logic       regdst,
    output logic       memtoreg,
    output logic       memwrite,
    output logic       retire,
    output logic       illegal_op
);

    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_RTYP = 6'b000000;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_ADDI = 6'b001000;
`ifdef MC_JUMP_EN
    localparam logic [5:0] OP_J    = 6'b000010;
`endif

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_RTYPEEX = 4'd6,
        S_RTYPEWB = 4'd7,
        S_BEQEX   = 4'd8,
        S_ADDIEX  = 4'd9,
        S_ADDIWB  = 4'd10,
        S_JEX     = 4'd11
    } state_t;

    state_t state_reg;
    state_t state_next;

    logic ready;

    // With the handshake disabled, every memory access completes at once.
    assign ready = (USE_MEM_READY != 0) ? mem_ready : 1'b1;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= S_FETCH;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = S_FETCH;
        aluop      = 2'b00;
        alusrca    = 1'b0;
        alusrcb    = 2'b00;
        pcsrc      = 2'b00;
        iord       = 1'b0;
        irwrite    = 1'b0;
        pcwrite    = 1'b0;
        branch     = 1'b0;
        regwrite   = 1'b0;
        regdst     = 1'b0;
        memtoreg   = 1'b0;
        memwrite   = 1'b0;
        retire     = 1'b0;
        illegal_op = 1'b0;

        // Outputs are gated by reset_n directly so that an in-flight
        // register or memory write is dropped the moment reset asserts,
        // not at the next clock edge.
        if (reset_n) begin
            case (state_reg)
                S_FETCH: begin
                    alusrcb = 2'b01;
                    irwrite = ready;
                    pcwrite = ready;
                    state_next = ready ? S_DECODE : S_FETCH;
                end
                S_DECODE: begin
                    alusrcb = 2'b11;
                    case (op)
                        OP_LW, OP_SW: state_next = S_MEMADR;
                        OP_RTYP:      state_next = S_RTYPEEX;
                        OP_BEQ:       state_next = S_BEQEX;
                        OP_ADDI:      state_next = S_ADDIEX;
`ifdef MC_JUMP_EN
                        OP_J:         state_next = S_JEX;
`endif
                        default: begin
                            illegal_op = 1'b1;
                            state_next = S_FETCH;
                        end
                    endcase
                end
                S_MEMADR: begin
                    alusrca = 1'b1;
                    alusrcb = 2'b10;
                    // Only lw/sw reach here; anything but sw is a load.
                    state_next = (op == OP_SW) ? S_MEMWR : S_MEMRD;
                end
                S_MEMRD: begin
                    iord = 1'b1;
                    state_next = ready ? S_MEMWB : S_MEMRD;
                end
                S_MEMWB: begin
                    memtoreg = 1'b1;
                    regwrite = 1'b1;
                    retire   = 1'b1;
                end
                S_MEMWR: begin
                    // Write strobe held until memory accepts it.
                    iord     = 1'b1;
                    memwrite = 1'b1;
                    retire   = ready;
                    state_next = ready ? S_FETCH : S_MEMWR;
                end
                S_RTYPEEX: begin
                    alusrca = 1'b1;
                    aluop   = 2'b10;
                    state_next = S_RTYPEWB;
                end
                S_RTYPEWB: begin
                    regdst   = 1'b1;
                    regwrite = 1'b1;
                    retire   = 1'b1;
                end
                S_BEQEX: begin
                    alusrca = 1'b1;
                    aluop   = 2'b01;
                    pcsrc   = 2'b01;
                    branch  = 1'b1;
                    retire  = 1'b1;
                end
                S_ADDIEX: begin
                    alusrca = 1'b1;
                    alusrcb = 2'b10;
                    state_next = S_ADDIWB;
                end
                S_ADDIWB: begin
                    regwrite = 1'b1;
                    retire   = 1'b1;
                end
`ifdef MC_JUMP_EN
                S_JEX: begin
                    pcsrc   = 2'b10;
                    pcwrite = 1'b1;
                    retire  = 1'b1;
                end
`endif
                // Unused encodings (and JEX when jumps are disabled)
                // fall back to FETCH with all outputs inactive.
                default: state_next = S_FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_mc_control_fsm.sv
// ---------------------------------------------------------------------------
// tb_mc_control_fsm
//
// Instruction-level reference model: each instruction is a numbered sequence
// of steps (0 = fetch, 1 = decode, 2.. = execute/memory/writeback) whose
// outputs are listed per instruction kind. Directed runs pin the model with
// literal expectations; random runs cover stalls, op noise and resets.
// ---------------------------------------------------------------------------
module tb_mc_control_fsm;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [5:0] op;
    logic       mem_ready;
    logic [1:0] aluop;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] pcsrc;
    logic       iord, irwrite, pcwrite, branch, regwrite, regdst;
    logic       memtoreg, memwrite, retire, illegal_op;

    always #5 clk = ~clk;

    mc_control_fsm dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .op         (op),
        .mem_ready  (mem_ready),
        .aluop      (aluop),
        .alusrca    (alusrca),
        .alusrcb    (alusrcb),
        .pcsrc      (pcsrc),
        .iord       (iord),
        .irwrite    (irwrite),
        .pcwrite    (pcwrite),
        .branch     (branch),
        .regwrite   (regwrite),
        .regdst     (regdst),
        .memtoreg   (memtoreg),
        .memwrite   (memwrite),
        .retire     (retire),
        .illegal_op (illegal_op)
    );

    // Bit layout of the output vector.
    localparam int B_ILL = 0, B_RET = 1, B_MW = 2, B_M2R = 3, B_RD = 4, B_RW = 5;
    localparam int B_BR = 6, B_PCW = 7, B_IRW = 8, B_IORD = 9;

    logic [16:0] dut_v;
    assign dut_v = {aluop, alusrca, alusrcb, pcsrc, iord, irwrite, pcwrite,
                    branch, regwrite, regdst, memtoreg, memwrite, retire, illegal_op};

    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_RTYP = 6'b000000;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_BAD  = 6'b111111;

    localparam int K_LW = 0, K_SW = 1, K_R = 2, K_BEQ = 3, K_ADDI = 4, K_J = 5, K_ILL = 6;

    int checks = 0;
    int errors = 0;

    int step_m = 0;
    int kind_m = K_ILL;
    int ncyc_m = 0;

    function automatic int classify(input logic [5:0] o);
        case (o)
            OP_LW:   return K_LW;
            OP_SW:   return K_SW;
            OP_RTYP: return K_R;
            OP_BEQ:  return K_BEQ;
            OP_ADDI: return K_ADDI;
`ifdef MC_JUMP_EN
            OP_J:    return K_J;
`endif
            default: return K_ILL;
        endcase
    endfunction

    // Kind is decided from op in decode; lw vs sw is confirmed in the address step.
    function automatic int eff_kind(input int st, input int kd, input logic [5:0] o);
        if (st == 1) return classify(o);
        if (st == 2 && (kd == K_LW || kd == K_SW)) return (o == OP_SW) ? K_SW : K_LW;
        return kd;
    endfunction

    function automatic int last_step(input int kd);
        case (kd)
            K_LW:    return 4;
            K_SW:    return 3;
            K_R:     return 3;
            K_BEQ:   return 2;
            K_ADDI:  return 3;
            K_J:     return 2;
            default: return 1;
        endcase
    endfunction

    function automatic bit waits_mem(input int st, input int kd);
        return (st == 0) || (st == 3 && (kd == K_LW || kd == K_SW));
    endfunction

    function automatic logic [16:0] model_out(input int st, input int kd,
                                              input logic mr, input logic rn);
        logic [1:0] a_op, s_b, p_src;
        logic s_a, io, irw, pcw, br, rw, rd, m2r, mw, ret, ill;
        a_op = 2'b00; s_b = 2'b00; p_src = 2'b00;
        {s_a, io, irw, pcw, br, rw, rd, m2r, mw, ret, ill} = '0;
        if (rn) begin
            if (st == 0) begin
                s_b = 2'b01; irw = mr; pcw = mr;
            end else if (st == 1) begin
                s_b = 2'b11; ill = (kd == K_ILL);
            end else if (st == 2) begin
                case (kd)
                    K_LW, K_SW, K_ADDI: begin s_a = 1'b1; s_b = 2'b10; end
                    K_R:   begin s_a = 1'b1; a_op = 2'b10; end
                    K_BEQ: begin s_a = 1'b1; a_op = 2'b01; p_src = 2'b01; br = 1'b1; ret = 1'b1; end
                    K_J:   begin p_src = 2'b10; pcw = 1'b1; ret = 1'b1; end
                    default: ;
                endcase
            end else if (st == 3) begin
                case (kd)
                    K_LW:   io = 1'b1;
                    K_SW:   begin io = 1'b1; mw = 1'b1; ret = mr; end
                    K_R:    begin rd = 1'b1; rw = 1'b1; ret = 1'b1; end
                    K_ADDI: begin rw = 1'b1; ret = 1'b1; end
                    default: ;
                endcase
            end else if (st == 4 && kd == K_LW) begin
                m2r = 1'b1; rw = 1'b1; ret = 1'b1;
            end
        end
        return {a_op, s_a, s_b, p_src, io, irw, pcw, br, rw, rd, m2r, mw, ret, ill};
    endfunction

    task automatic check_lit(input string name, input int act, input int req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    // One clock: drive at posedge+1, compare at negedge, advance model at posedge.
    task automatic cycle(input logic mr, input logic [5:0] opv, output logic [16:0] obs);
        logic [16:0] expv;
        int kd;
        mem_ready = mr;
        op = opv;
        @(negedge clk);
        kd = eff_kind(step_m, kind_m, opv);
        expv = model_out(step_m, kd, mr, reset_n);
        obs = dut_v;
        checks++;
        if (obs !== expv) begin
            errors++;
            $display("FAIL cycle_model t=%0t step=%0d op=%b actual=%b required=%b",
                     $time, step_m, opv, obs, expv);
        end
        @(posedge clk);
        if (!reset_n) begin
            step_m = 0;
            ncyc_m = 0;
        end else begin
            kind_m = kd;
            ncyc_m++;
            if (waits_mem(step_m, kd) && !mr) begin
                // stalled
            end else if (step_m == last_step(kd)) begin
                $display("TXN op=%b kind=%0d cycles=%0d", opv, kd, ncyc_m);
                step_m = 0;
                ncyc_m = 0;
            end else begin
                step_m++;
            end
        end
        #1;
    endtask

    // Runs one instruction from FETCH with fs fetch stalls and ms stalls in
    // the data memory step; reports its cycle count and per-cycle outputs.
    task automatic run_instr(input logic [5:0] opv, input int fs, input int ms,
                             output int ncyc, output logic [16:0] tr [20]);
        logic [16:0] obs;
        logic mr;
        bit done;
        done = 0;
        ncyc = 0;
        for (int k = 0; k < 20; k++) tr[k] = '0;
        for (int k = 0; k < 20 && !done; k++) begin
            if (k < fs) mr = 1'b0;
            else if (k == fs) mr = 1'b1;
            else if (k >= fs + 3 && k < fs + 3 + ms) mr = 1'b0;
            else mr = 1'b1;
            cycle(mr, opv, obs);
            tr[k] = obs;
            ncyc = k + 1;
            if (obs[B_RET] || obs[B_ILL]) done = 1;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL instr_timeout op=%b actual=no_end required=retire_or_illegal", opv);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [16:0] obs;
        logic [16:0] tr [20];
        logic [5:0] cur_op;
        logic [5:0] op_tbl [7];
        int n;
        int rw_any;

        op_tbl[0] = OP_LW;  op_tbl[1] = OP_SW;   op_tbl[2] = OP_RTYP;
        op_tbl[3] = OP_BEQ; op_tbl[4] = OP_ADDI; op_tbl[5] = OP_J;
        op_tbl[6] = OP_BAD;

        // Reset state
        reset_n = 1'b0;
        mem_ready = 1'b1;
        op = 6'd0;
        #1;
        check_lit("reset_outputs_zero", int'(dut_v), 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        cycle(1'b1, OP_RTYP, obs);
        check_lit("fetch_after_reset_alusrcb", int'(obs[13:12]), 1);
        check_lit("fetch_after_reset_aluop", int'(obs[16:15]), 0);
        // finish that R-type
        cycle(1'b1, OP_RTYP, obs);
        cycle(1'b1, OP_RTYP, obs);
        cycle(1'b1, OP_RTYP, obs);

        // R-type
        run_instr(OP_RTYP, 0, 0, n, tr);
        check_lit("r_cycles", n, 4);
        check_lit("r_aluop_ex", int'(tr[2][16:15]), 2);
        check_lit("r_wb_rw_rd_ret", int'({tr[3][B_RW], tr[3][B_RD], tr[3][B_RET]}), 7);

        // lw with 2 fetch stalls and 3 memory stalls
        run_instr(OP_LW, 2, 3, n, tr);
        check_lit("lw_cycles", n, 10);
        check_lit("lw_irwrite_pattern", int'({tr[0][B_IRW], tr[1][B_IRW], tr[2][B_IRW]}), 1);
        check_lit("lw_wb_m2r_rw", int'({tr[9][B_M2R], tr[9][B_RW]}), 3);

        // sw with 1 memory stall
        run_instr(OP_SW, 0, 1, n, tr);
        check_lit("sw_cycles", n, 5);
        check_lit("sw_memwrite_held", int'({tr[3][B_MW], tr[4][B_MW]}), 3);
        check_lit("sw_retire_with_ready", int'({tr[3][B_RET], tr[4][B_RET]}), 1);
        rw_any = 0;
        for (int k = 0; k < 5; k++) rw_any = rw_any | int'(tr[k][B_RW]);
        check_lit("sw_no_regwrite", rw_any, 0);

        // beq
        run_instr(OP_BEQ, 0, 0, n, tr);
        check_lit("beq_cycles", n, 3);
        check_lit("beq_aluop", int'(tr[2][16:15]), 1);
        check_lit("beq_branch", int'(tr[2][B_BR]), 1);
        check_lit("beq_pcsrc", int'(tr[2][11:10]), 1);

        // addi
        run_instr(OP_ADDI, 0, 0, n, tr);
        check_lit("addi_cycles", n, 4);
        check_lit("addi_ex_aluop", int'(tr[2][16:15]), 0);
        check_lit("addi_ex_alusrcb", int'(tr[2][13:12]), 2);
        check_lit("addi_wb_rw_rd", int'({tr[3][B_RW], tr[3][B_RD]}), 2);

        // jump
        run_instr(OP_J, 0, 0, n, tr);
`ifdef MC_JUMP_EN
        check_lit("j_cycles", n, 3);
        check_lit("j_pcsrc", int'(tr[2][11:10]), 2);
        check_lit("j_pcwrite", int'(tr[2][B_PCW]), 1);
`else
        check_lit("j_illegal_cycles", n, 2);
        check_lit("j_illegal_pulse", int'(tr[1][B_ILL]), 1);
        check_lit("j_illegal_no_retire", int'(tr[1][B_RET]), 0);
        cycle(1'b1, OP_RTYP, obs);
        check_lit("j_illegal_back_to_fetch", int'(obs[13:12]), 1);
        cycle(1'b1, OP_RTYP, obs);
        cycle(1'b1, OP_RTYP, obs);
        cycle(1'b1, OP_RTYP, obs);
`endif

        // opcode 111111
        run_instr(OP_BAD, 0, 0, n, tr);
        check_lit("bad_cycles", n, 2);
        check_lit("bad_illegal_pulse", int'(tr[1][B_ILL]), 1);

        // Async reset mid-MEMWR
        cycle(1'b1, OP_SW, obs);
        cycle(1'b1, OP_SW, obs);
        cycle(1'b1, OP_SW, obs);
        mem_ready = 1'b0;
        #2;
        check_lit("memwr_strobe_before_reset", int'(dut_v[B_MW]), 1);
        reset_n = 1'b0;
        #1;
        check_lit("memwrite_async_drop", int'(dut_v[B_MW]), 0);
        check_lit("all_zero_in_reset", int'(dut_v), 0);
        @(posedge clk);
        #1;
        step_m = 0;
        ncyc_m = 0;
        reset_n = 1'b1;
        cycle(1'b1, OP_ADDI, obs);
        check_lit("fetch_after_abort_alusrcb", int'(obs[13:12]), 1);
        check_lit("fetch_after_abort_aluop", int'(obs[16:15]), 0);

        // Random traffic: stalls, op noise outside sampling steps, rare resets
        cur_op = OP_RTYP;
        for (int i = 0; i < 4000; i++) begin
            logic mr;
            logic [5:0] opv;
            mr = ($urandom_range(0, 3) != 0);
            if (step_m == 0) begin
                if ($urandom_range(0, 7) == 0) cur_op = 6'($urandom_range(0, 63));
                else cur_op = op_tbl[$urandom_range(0, 6)];
            end
            if (step_m == 1 || step_m == 2) opv = cur_op;
            else opv = 6'($urandom_range(0, 63));
            if ($urandom_range(0, 399) == 0) begin
                reset_n = 1'b0;
                cycle(mr, opv, obs);
                reset_n = 1'b1;
            end else begin
                cycle(mr, opv, obs);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mc_control_fsm.md
Name: mc_control_fsm

Overview:
- Multicycle MIPS main controller: sequences each instruction through fetch, decode, execute, memory and writeback states.
- Drives datapath enables and muxes, and produces the 2-bit aluop consumed directly by the downstream ALU decoder.
- aluop encoding: 00 = add, 01 = subtract, 10 = use funct field.
- Supported opcodes: lw, sw, R-type, beq, addi; j when enabled.
- A memory ready handshake lets it stall on slow instruction/data memory.

Parameters:
- USE_MEM_READY, 1, when 0 mem_ready is ignored and treated as constant 1.

Ports:
- clk  input  1  rising-edge clock
- reset_n  input  1  asynchronous active-low reset
- op  input  6  instr[31:26] from instruction register
- mem_ready  input  1  memory access completes this cycle
- aluop  output  2  to ALU decoder
- alusrca  output  1  0 = PC, 1 = register A
- alusrcb  output  2  00 = B, 01 = const 4, 10 = signimm, 11 = signimm<<2
- pcsrc  output  2  00 = ALU result, 01 = ALUOut, 10 = jump target
- iord  output  1  memory address select, 1 = ALUOut
- irwrite  output  1  instruction register enable
- pcwrite  output  1  unconditional PC enable
- branch  output  1  PC enable qualified by zero in datapath
- regwrite  output  1  register file write
- regdst  output  1  1 = rd, 0 = rt
- memtoreg  output  1  1 = data register
- memwrite  output  1  memory write strobe
- retire  output  1  one-cycle pulse, instruction complete
- illegal_op  output  1  one-cycle pulse, unsupported opcode in DECODE

Behaviour:
- 4-bit state register, async-cleared to FETCH. Unused encodings go to FETCH next cycle.
- While reset_n = 0, all enables/strobes are 0: irwrite, pcwrite, branch, regwrite, memwrite, retire, illegal_op. All mux selects and aluop are 0.
- Outputs are decoded from state, plus mem_ready gating where noted. Any output not listed for a state is 0.
- FETCH:
  - alusrcb=01, aluop=00; irwrite = pcwrite = mem_ready.
  - mem_ready -> DECODE, else stay.
- DECODE:
  - alusrcb=11, aluop=00.
  - op 100011/101011 -> MEMADR; 000000 -> RTYPEEX; 000100 -> BEQEX; 001000 -> ADDIEX; 000010 -> JEX (macro only).
  - Any other op: illegal_op=1, -> FETCH, no retire.
- MEMADR: alusrca=1, alusrcb=10, aluop=00. lw -> MEMRD, sw -> MEMWR.
- MEMRD: iord=1. mem_ready -> MEMWB, else stay.
- MEMWB: memtoreg=1, regwrite=1, retire=1. -> FETCH.
- MEMWR:
  - iord=1, memwrite=1, held every cycle until mem_ready.
  - retire = mem_ready; mem_ready -> FETCH.
- RTYPEEX: alusrca=1, alusrcb=00, aluop=10. -> RTYPEWB.
- RTYPEWB: regdst=1, regwrite=1, retire=1. -> FETCH.
- BEQEX: alusrca=1, alusrcb=00, aluop=01, pcsrc=01, branch=1, retire=1. -> FETCH.
- ADDIEX: alusrca=1, alusrcb=10, aluop=00. -> ADDIWB.
- ADDIWB: regwrite=1, retire=1. -> FETCH.
- JEX: pcsrc=10, pcwrite=1, retire=1. -> FETCH.
- Latency with mem_ready always 1:
  - lw 5 cycles; sw, R-type, addi 4; beq, j 3; illegal 2.
- op is sampled only in DECODE and MEMADR; op changes in other states have no effect.
- Reset asserted mid-instruction:
  - Immediate abort; pending regwrite/memwrite drop asynchronously.
  - First cycle after reset_n rises is FETCH.
- USE_MEM_READY=0: FETCH, MEMRD and MEMWR each last exactly one cycle.

Optional Feature:
- MC_JUMP_EN defined: op 000010 in DECODE -> JEX.
- Undefined: JEX is never entered; op 000010 is illegal (illegal_op pulse, return to FETCH). Reaching the JEX encoding by other means is treated as unused and goes to FETCH.

Test Plan:
- Reset: reset_n=0 mid-MEMWR with memwrite=1 -> memwrite=0 immediately; after release, FETCH with alusrcb=01, aluop=00.
- R-type: op=000000, mem_ready=1 -> 4 cycles; aluop=10 in RTYPEEX; regwrite=1, regdst=1, retire=1 in cycle 4.
- lw with stalls: op=100011, mem_ready low 2 cycles in FETCH and 3 in MEMRD -> irwrite only in the mem_ready cycle; total 10 cycles; memtoreg=1, regwrite=1 at end.
- sw: op=101011, mem_ready low 1 cycle in MEMWR -> memwrite high 2 consecutive cycles; retire coincident with mem_ready; regwrite never asserted.
- beq and addi: op=000100 -> aluop=01, branch=1, pcsrc=01 in cycle 3. op=001000 -> aluop=00, alusrcb=10 in cycle 3; regwrite=1, regdst=0 in cycle 4.
- Illegal/jump: op=000010 -> with MC_JUMP_EN, pcsrc=10 and pcwrite=1 in cycle 3; without it, illegal_op=1 in cycle 2 and FETCH in cycle 3. op=111111 -> illegal_op in both builds.
